// File: rtl/phv_assembler.sv
// Rebuilds a full PHV from 64 ALU container results and the queued metadata tail.
// Optional build macro PHV_ASM_STATS_EN adds handshake and stall counters.
module phv_assembler #(
  parameter int STAGE_ID     = 0,
  parameter int PHV_LEN      = 4*8*64+256,
  parameter int width_4B     = 32,
  parameter int REMAIN_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [255:0]                    remain_in,
  input  logic                            remain_in_valid,
  output logic                            remain_ready,
  input  logic [width_4B*64-1:0]          alu_out,
  input  logic                            alu_out_valid,
  output logic                            alu_ready,
  output logic [PHV_LEN-1:0]              phv_out,
  output logic                            phv_out_valid,
  input  logic                            phv_out_ready,
  output logic [$clog2(REMAIN_DEPTH):0]   fifo_count,
`ifdef PHV_ASM_STATS_EN
  output logic [31:0]                     asm_pkt_count,
  output logic [31:0]                     asm_stall_count,
`endif
  output logic                            err_underflow,
  output logic                            err_overflow
);

  localparam int PTR_W = $clog2(REMAIN_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (STAGE_ID < 0 || REMAIN_DEPTH < 2 || (REMAIN_DEPTH & (REMAIN_DEPTH - 1)) != 0 ||
      PHV_LEN != width_4B*64 + 256) begin : g_bad_params
    $error("phv_assembler: inconsistent parameters");
  end

  logic [255:0]         mem_q [REMAIN_DEPTH];
  logic [255:0]         mem_d [REMAIN_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PHV_LEN-1:0]   phv_q, phv_d;
  logic                 valid_q, valid_d;
  logic                 err_under_q, err_under_d;
  logic                 err_over_q, err_over_d;

  logic                 fifo_empty;
  logic                 out_free;
  logic                 push;
  logic                 fire;
  logic [255:0]         fifo_head;

  assign fifo_empty   = (count_q == '0);
  assign remain_ready = (count_q < CNT_W'(REMAIN_DEPTH));
  assign out_free     = ~valid_q | phv_out_ready;
  assign alu_ready    = ~fifo_empty & out_free;
  assign push         = remain_in_valid & remain_ready;
  assign fire         = alu_out_valid & alu_ready;
  // Head comes from the registered array, so a same-cycle push never bypasses.
  assign fifo_head    = mem_q[rd_ptr_q];

  always_comb begin
    for (int i = 0; i < REMAIN_DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = remain_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !fire)      count_d = count_q + CNT_W'(1);
    else if (!push && fire) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    phv_d   = phv_q;
    valid_d = valid_q;
    if (fire) begin
      // Container 63 lands at the MSB, tail occupies the low 256 bits.
      phv_d   = {alu_out, fifo_head};
      valid_d = 1'b1;
    end else if (phv_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    err_under_d = err_under_q | (alu_out_valid & fifo_empty);
    err_over_d  = err_over_q  | (remain_in_valid & ~remain_ready);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < REMAIN_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      phv_q       <= '0;
      valid_q     <= 1'b0;
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      phv_q       <= phv_d;
      valid_q     <= valid_d;
      err_under_q <= err_under_d;
      err_over_q  <= err_over_d;
    end
  end

  assign phv_out       = phv_q;
  assign phv_out_valid = valid_q;
  assign fifo_count    = count_q;
  assign err_underflow = err_under_q;
  assign err_overflow  = err_over_q;

`ifdef PHV_ASM_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (valid_q && phv_out_ready)  pkt_cnt_d   = pkt_cnt_q + 32'd1;
    if (valid_q && !phv_out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign asm_pkt_count   = pkt_cnt_q;
  assign asm_stall_count = stall_cnt_q;
`endif

endmodule
